// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer ahead of the CP0 register file: arbitrates sync exceptions
// and masked level interrupts, then issues the CP0 write strobes and fetch redirect.
module exc_ctrl #(
  parameter int unsigned N_IRQ     = 6,
  parameter logic [31:0] VECTOR_PC = 32'h0000_0180
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             exc_ri_i,
  input  logic             exc_ov_i,
  input  logic             exc_sys_i,
  input  logic             eret_i,
  input  logic [31:0]      status_i,
  input  logic [31:0]      epc_i,
  output logic             wcau_o,
  output logic             wepc_o,
  output logic             wsta_o,
  output logic             exc_o,
  output logic             inta_o,
  output logic [31:0]      cause_data_o,
  output logic             stall_req_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAVE   = 3'd1,
    ENTER  = 3'd2,
    VECTOR = 3'd3,
    RET    = 3'd4,
    RETJ   = 3'd5
  } state_e;

  state_e           state_q;
  logic [N_IRQ-1:0] irq_q;
  logic [7:0]       ip_q;
  logic [4:0]       code_q;
  logic             wcau_q, wepc_q, wsta_q, exc_q, inta_q, stall_q, redirect_q;

  logic [7:0] ip_w;
  logic [4:0] code_w;
  logic       sync_w, async_w;
  logic       unused_status_w;

  always_comb begin
    ip_w              = '0;
    ip_w[N_IRQ-1:0]   = irq_q;
    sync_w            = exc_ri_i | exc_ov_i | exc_sys_i;
    async_w           = status_i[0] & (|(irq_q & status_i[8 +: N_IRQ]));
    if (exc_ri_i)       code_w = 5'd10;
    else if (exc_ov_i)  code_w = 5'd12;
    else if (exc_sys_i) code_w = 5'd8;
    else                code_w = 5'd0;
  end

  assign unused_status_w = ^{status_i[31:8+N_IRQ], status_i[7:1]};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      irq_q      <= '0;
      ip_q       <= '0;
      code_q     <= '0;
      wcau_q     <= 1'b0;
      wepc_q     <= 1'b0;
      wsta_q     <= 1'b0;
      exc_q      <= 1'b0;
      inta_q     <= 1'b0;
      stall_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      irq_q      <= irq_i;
      wcau_q     <= 1'b0;
      wepc_q     <= 1'b0;
      wsta_q     <= 1'b0;
      exc_q      <= 1'b0;
      inta_q     <= 1'b0;
      redirect_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          stall_q <= 1'b0;
          // Inputs below a taken event are dropped, not queued.
          if (sync_w || async_w) begin
            state_q <= SAVE;
            ip_q    <= ip_w;
            code_q  <= code_w;
            wcau_q  <= 1'b1;
            wepc_q  <= 1'b1;
            inta_q  <= ~sync_w;
            stall_q <= 1'b1;
          end else if (eret_i) begin
            state_q <= RET;
            wsta_q  <= 1'b1;
            stall_q <= 1'b1;
          end
        end
        SAVE: begin
          state_q <= ENTER;
          wsta_q  <= 1'b1;
          exc_q   <= 1'b1;
          stall_q <= 1'b1;
        end
        ENTER: begin
          state_q    <= VECTOR;
          redirect_q <= 1'b1;
          stall_q    <= 1'b1;
        end
        RET: begin
          state_q    <= RETJ;
          redirect_q <= 1'b1;
          stall_q    <= 1'b1;
        end
        VECTOR, RETJ: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    redirect_pc_o = '0;
    if (state_q == VECTOR)    redirect_pc_o = VECTOR_PC;
    else if (state_q == RETJ) redirect_pc_o = epc_i;
  end

  assign wcau_o       = wcau_q;
  assign wepc_o       = wepc_q;
  assign wsta_o       = wsta_q;
  assign exc_o        = exc_q;
  assign inta_o       = inta_q;
  assign stall_req_o  = stall_q;
  assign redirect_o   = redirect_q;
  assign busy_o       = (state_q != IDLE);
  assign cause_data_o = {16'b0, ip_q, 1'b0, code_q, 2'b0};

endmodule
